// File: rtl/keypad_scanner.sv
// keypad_scanner: 3x3 matrix keypad scanner with 2-FF column synchroniser,
// per-frame debounce, multi-key rejection and release confirmation.
// Emits one key_valid strobe per accepted press with key_code = 3*row+col.
// Optional macro KEYPAD_IDLE_CODE_EN: key_code reads 4'd15 on every cycle
// except the strobe cycle; otherwise it holds the last accepted index.
module keypad_scanner #(
  parameter int SETTLE_CYCLES   = 4,
  parameter int DEBOUNCE_FRAMES = 3,
  parameter int RELEASE_FRAMES  = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] col_n,
  output logic [2:0] row_n,
  output logic [3:0] key_code,
  output logic       key_valid,
  output logic       key_busy
);

  localparam int SW = $clog2(SETTLE_CYCLES + 1);
  localparam int DW = $clog2(DEBOUNCE_FRAMES + 1);
  localparam int RW = $clog2(RELEASE_FRAMES + 1);

  // Columns need two cycles through the synchroniser plus one to be sampled.
  if (SETTLE_CYCLES < 3) begin : g_settle_chk
    $error("keypad_scanner: SETTLE_CYCLES must be >= 3");
  end
  if (DEBOUNCE_FRAMES < 1 || RELEASE_FRAMES < 1) begin : g_frames_chk
    $error("keypad_scanner: DEBOUNCE_FRAMES and RELEASE_FRAMES must be >= 1");
  end

  typedef enum logic [1:0] {IDLE, DEBOUNCE, PRESSED, RELEASE} state_t;

  logic [2:0]    r_sync1, r_col_sync;
  logic [1:0]    r_row;
  logic [SW-1:0] r_settle;
  logic [2:0]    r_row_n;
  logic [5:0]    r_map;
  state_t        r_state;
  logic [3:0]    r_cand;
  logic [DW-1:0] r_cnt;
  logic [RW-1:0] r_rcnt;
  logic          r_valid, r_busy;
  logic [3:0]    r_code;

  logic          w_sample, w_frame_end, w_single;
  logic [8:0]    w_map, w_cand_oh;
  logic [3:0]    w_idx;

  assign w_sample    = (r_settle == SW'(SETTLE_CYCLES - 1));
  assign w_frame_end = w_sample && (r_row == 2'd2);
  // Rows 0/1 come from the stored samples; row 2 is being sampled this cycle.
  assign w_map       = {~r_col_sync, r_map};
  assign w_single    = (w_map != 9'd0) && ((w_map & (w_map - 9'd1)) == 9'd0);
  assign w_cand_oh   = 9'd1 << r_cand;

  // Index of the set map bit; only meaningful when w_single is true.
  always_comb begin
    w_idx = 4'd15;
    for (int i = 0; i < 9; i++)
      if (w_map[i]) w_idx = 4'(i);
  end

  // Two-flop synchroniser for the asynchronous column inputs.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_sync1    <= 3'b111;
      r_col_sync <= 3'b111;
    end else begin
      r_sync1    <= col_n;
      r_col_sync <= r_sync1;
    end
  end

  // Row scan: each row held SETTLE_CYCLES, columns captured on the last slot cycle.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_row    <= 2'd0;
      r_settle <= '0;
      r_row_n  <= 3'b110;
      r_map    <= '0;
    end else if (w_sample) begin
      r_settle <= '0;
      case (r_row)
        2'd0:    begin r_map[2:0] <= ~r_col_sync; r_row <= 2'd1; r_row_n <= 3'b101; end
        2'd1:    begin r_map[5:3] <= ~r_col_sync; r_row <= 2'd2; r_row_n <= 3'b011; end
        default: begin                            r_row <= 2'd0; r_row_n <= 3'b110; end
      endcase
    end else begin
      r_settle <= r_settle + SW'(1);
    end
  end

  // Press/release FSM, advanced once per frame; outputs are registered here.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= IDLE;
      r_cand  <= 4'd0;
      r_cnt   <= '0;
      r_rcnt  <= '0;
      r_valid <= 1'b0;
      r_busy  <= 1'b0;
      r_code  <= 4'd15;
    end else begin
      r_valid <= 1'b0;
`ifdef KEYPAD_IDLE_CODE_EN
      if (r_valid) r_code <= 4'd15;
`endif
      if (w_frame_end) begin
        case (r_state)
          IDLE: if (w_single) begin
            r_cand <= w_idx;
            r_cnt  <= DW'(1);
            if (DEBOUNCE_FRAMES <= 1) begin
              r_state <= PRESSED;
              r_valid <= 1'b1;
              r_code  <= w_idx;
              r_busy  <= 1'b1;
            end else begin
              r_state <= DEBOUNCE;
            end
          end
          DEBOUNCE: if (w_map == w_cand_oh) begin
            if (r_cnt >= DW'(DEBOUNCE_FRAMES - 1)) begin
              r_cnt   <= DW'(DEBOUNCE_FRAMES);
              r_state <= PRESSED;
              r_valid <= 1'b1;
              r_code  <= r_cand;
              r_busy  <= 1'b1;
            end else begin
              r_cnt <= r_cnt + DW'(1);
            end
          end else begin
            r_state <= IDLE;
            r_cnt   <= '0;
          end
          PRESSED: if (w_map == 9'd0) begin
            if (RELEASE_FRAMES <= 1) begin
              r_state <= IDLE;
              r_busy  <= 1'b0;
              r_rcnt  <= '0;
            end else begin
              r_state <= RELEASE;
              r_rcnt  <= RW'(1);
            end
          end
          default: if (w_map == 9'd0) begin
            if (r_rcnt >= RW'(RELEASE_FRAMES - 1)) begin
              r_state <= IDLE;
              r_busy  <= 1'b0;
              r_rcnt  <= '0;
            end else begin
              r_rcnt <= r_rcnt + RW'(1);
            end
          end else begin
            r_state <= PRESSED;
            r_rcnt  <= '0;
          end
        endcase
      end
    end
  end

  assign row_n     = r_row_n;
  assign key_code  = r_code;
  assign key_valid = r_valid;
  assign key_busy  = r_busy;

endmodule
